// File: rtl/lsu_mem_requester_pkg.sv
// Shared types for the LSU memory requester: FSM states, access sizes,
// RV32I load/store funct3 codes and op legality helpers.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        NB_BYTE = 2'b00,
        NB_HALF = 2'b01,
        NB_WORD = 2'b10
    } n_bytes_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic n_bytes_e f3_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b01) return NB_HALF;
        if (f3[1:0] == 2'b10) return NB_WORD;
        return NB_BYTE;
    endfunction

    // Illegal encodings share the misaligned reject path.
    function automatic logic op_rejected(
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic legal;
        logic misal;
        if (is_store)
            legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW)
                 || (f3 == F3_LBU) || (f3 == F3_LHU);
        misal = ((f3[1:0] == 2'b01) && a[0])
             || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return !legal || misal;
    endfunction

endpackage

// File: rtl/lsu_mem_requester_if.sv
// Execute-side op/response and data-memory request bundle.
// master = LSU requester, slave = environment (execute/wb/memory).
interface lsu_mem_requester_if #(
    parameter int ADDR_W = memory_pkg::MEM_ADDR_WIDTH
) ();

    logic              op_valid;
    logic              op_ready;
    logic              op_is_store;
    logic [2:0]        op_funct3;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              rsp_misaligned;

    logic              mem_req;
    logic              mem_write_en;
    logic [1:0]        mem_n_bytes;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_w_data;
    logic [31:0]       mem_r_data;
    logic              mem_addr_err;

    modport master (
        input  op_valid, op_is_store, op_funct3, op_addr, op_wdata,
        input  mem_r_data, mem_addr_err,
        output op_ready, rsp_valid, rsp_data, rsp_err, rsp_misaligned,
        output mem_req, mem_write_en, mem_n_bytes, mem_addr, mem_w_data
    );

    modport slave (
        output op_valid, op_is_store, op_funct3, op_addr, op_wdata,
        output mem_r_data, mem_addr_err,
        input  op_ready, rsp_valid, rsp_data, rsp_err, rsp_misaligned,
        input  mem_req, mem_write_en, mem_n_bytes, mem_addr, mem_w_data
    );

endinterface

// File: rtl/lsu_mem_requester_load_align.sv
// Load lane extraction and sign/zero extension from the aligned
// memory word.
module lsu_load_align
    import memory_pkg::*;
(
    input  logic [31:0] r_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = r_data[{addr, 3'b000} +: 8];
        half_v = r_data[{addr[1], 4'b0000} +: 16];
        data   = r_data;
        unique case (funct3)
            F3_LB:   data = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  data = {24'h0, byte_v};
            F3_LH:   data = {{16{half_v[15]}}, half_v};
            F3_LHU:  data = {16'h0, half_v};
            default: data = r_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_requester.sv
// Core-side data-memory requester: one load/store per transaction,
// alignment check, store lane replication, load extract/extend.
module lsu_mem_requester
    import memory_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_WIDTH,
    parameter int MEM_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    lsu_mem_requester_if.master bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              op_ready_q, op_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_mis_q, rsp_mis_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    n_bytes_e          mem_nb_q, mem_nb_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wd_q, mem_wd_d;

    logic              accept;
    n_bytes_e          op_nb;
    logic [31:0]       wdata_rep;
    logic [31:0]       load_data;

    lsu_load_align u_align (
        .r_data (bus.mem_r_data),
        .addr   (mem_addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        op_nb = f3_size(bus.op_funct3);
        unique case (op_nb)
            NB_BYTE: wdata_rep = {4{bus.op_wdata[7:0]}};
            NB_HALF: wdata_rep = {2{bus.op_wdata[15:0]}};
            default: wdata_rep = bus.op_wdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        op_ready_d  = op_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_mis_d   = rsp_mis_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_nb_d    = mem_nb_q;
        mem_addr_d  = mem_addr_q;
        mem_wd_d    = mem_wd_q;
        accept      = bus.op_valid && op_ready_q;

        unique case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    op_ready_d = 1'b0;
                    f3_d       = bus.op_funct3;
                    if (op_rejected(bus.op_is_store, bus.op_funct3,
                                    bus.op_addr[1:0])) begin
                        state_d     = LSU_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = LSU_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = bus.op_is_store;
                        mem_nb_d   = op_nb;
                        mem_addr_d = bus.op_addr;
                        mem_wd_d   = wdata_rep;
                    end
                end
            end
            LSU_REQ: begin
                mem_req_d = 1'b0;
                cnt_d     = CNT_LOAD;
                state_d   = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = LSU_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.mem_addr_err;
                    rsp_mis_d   = 1'b0;
                    rsp_data_d  = (mem_we_q || bus.mem_addr_err)
                                ? '0 : load_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LSU_RESP: begin
                state_d     = LSU_IDLE;
                op_ready_d  = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                rsp_mis_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            op_ready_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_nb_q    <= NB_BYTE;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            op_ready_q  <= op_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_nb_q    <= mem_nb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    assign bus.op_ready       = op_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.rsp_misaligned = rsp_mis_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_write_en   = mem_we_q;
    assign bus.mem_n_bytes    = mem_nb_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_w_data     = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Bench for lsu_mem_requester: vector table, corner sequences and
// randomized ops against a behavioural model, latencies 1 and 3.
module tb_lsu_mem_requester;
    import memory_pkg::*;

    localparam int AW = MEM_ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic          op_valid = 1'b0;
    logic          op_is_store = 1'b0;
    logic [2:0]    op_funct3 = '0;
    logic [AW-1:0] op_addr = '0;
    logic [31:0]   op_wdata = '0;
    logic [31:0]   mem_r_data = '0;
    logic          mem_addr_err = 1'b0;

    lsu_mem_requester_if #(.ADDR_W(AW)) i1 ();
    lsu_mem_requester_if #(.ADDR_W(AW)) i3 ();

    assign i1.op_valid     = op_valid && !sel;
    assign i3.op_valid     = op_valid && sel;
    assign i1.op_is_store  = op_is_store;
    assign i3.op_is_store  = op_is_store;
    assign i1.op_funct3    = op_funct3;
    assign i3.op_funct3    = op_funct3;
    assign i1.op_addr      = op_addr;
    assign i3.op_addr      = op_addr;
    assign i1.op_wdata     = op_wdata;
    assign i3.op_wdata     = op_wdata;
    assign i1.mem_r_data   = mem_r_data;
    assign i3.mem_r_data   = mem_r_data;
    assign i1.mem_addr_err = mem_addr_err;
    assign i3.mem_addr_err = mem_addr_err;

    lsu_mem_requester #(.ADDR_W(AW), .MEM_LATENCY(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (i1.master)
    );

    lsu_mem_requester #(.ADDR_W(AW), .MEM_LATENCY(3)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (i3.master)
    );

    logic          o_ready, o_rv, o_err, o_mis, o_req, o_we;
    logic [31:0]   o_data, o_wd;
    logic [1:0]    o_nb;
    logic [AW-1:0] o_addr;

    assign o_ready = sel ? i3.op_ready       : i1.op_ready;
    assign o_rv    = sel ? i3.rsp_valid      : i1.rsp_valid;
    assign o_data  = sel ? i3.rsp_data       : i1.rsp_data;
    assign o_err   = sel ? i3.rsp_err        : i1.rsp_err;
    assign o_mis   = sel ? i3.rsp_misaligned : i1.rsp_misaligned;
    assign o_req   = sel ? i3.mem_req        : i1.mem_req;
    assign o_we    = sel ? i3.mem_write_en   : i1.mem_write_en;
    assign o_nb    = sel ? i3.mem_n_bytes    : i1.mem_n_bytes;
    assign o_addr  = sel ? i3.mem_addr       : i1.mem_addr;
    assign o_wd    = sel ? i3.mem_w_data     : i1.mem_w_data;

    typedef struct {
        logic          st;
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          err;
        logic          e_mis;
        logic          e_err;
        logic [31:0]   e_data;
        logic [31:0]   e_wd;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    function automatic void check(string name, logic [63:0] got,
                                  logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endfunction

    function automatic vec_t mk(logic st, logic [2:0] f3,
                                logic [AW-1:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic er, logic em,
                                logic ee, logic [31:0] ed,
                                logic [31:0] ewd);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.err = er; v.e_mis = em; v.e_err = ee; v.e_data = ed;
        v.e_wd = ewd;
        return v;
    endfunction

    // Reference: sizes, lanes and extension from plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int sz;
        int lane;
        bit legal;
        logic [31:0] m;
        logic [31:0] val;
        if (v.st) legal = (v.f3 <= 3'd2);
        else legal = (v.f3 <= 3'd2) || (v.f3 == 3'd4) || (v.f3 == 3'd5);
        sz = 1 << v.f3[1:0];
        lane = int'(v.addr) % 4;
        r.e_mis = !legal || (lane % sz != 0);
        m = (sz >= 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
        r.e_wd = 32'h0;
        for (int i = 0; i < 4; i += sz)
            r.e_wd = r.e_wd | ((v.wdata & m) << (8 * i));
        val = (v.rdata >> (8 * lane)) & m;
        if (!v.f3[2] && sz < 4 && val[8 * sz - 1]) val = val | ~m;
        r.e_err = !r.e_mis && v.err;
        r.e_data = (r.e_mis || v.st || v.err) ? 32'h0 : val;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input int lat, input string tag);
        int guard;
        int nreq;
        int nrsp;
        int req_k;
        int rsp_k;
        logic got_we, got_err, got_mis;
        logic [1:0] got_nb;
        logic [AW-1:0] got_addr;
        logic [31:0] got_wd, got_data;
        guard = 0; nreq = 0; nrsp = 0; req_k = 0; rsp_k = 0;
        got_we = 0; got_err = 0; got_mis = 0; got_nb = 0;
        got_addr = 0; got_wd = 0; got_data = 0;
        while (!o_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, 64'(o_ready), 64'd1);
        op_valid = 1'b1; op_is_store = v.st; op_funct3 = v.f3;
        op_addr = v.addr; op_wdata = v.wdata;
        mem_r_data = $urandom;
        mem_addr_err = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        op_valid = 1'b0; op_is_store = ~v.st;
        op_funct3 = 3'($urandom); op_addr = AW'($urandom);
        op_wdata = $urandom;
        for (int k = 1; k <= lat + 4; k++) begin
            if (o_req) begin
                nreq++; req_k = k; got_we = o_we; got_nb = o_nb;
                got_addr = o_addr; got_wd = o_wd;
            end
            if (o_rv) begin
                nrsp++; rsp_k = k; got_data = o_data;
                got_err = o_err; got_mis = o_mis;
            end
            mem_r_data = (k == lat + 1) ? v.rdata : $urandom;
            mem_addr_err = (k == lat + 1) ? v.err
                                          : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check({tag, " rsp_count"}, 64'(nrsp), 64'd1);
        check({tag, " rsp_cycle"}, 64'(rsp_k),
              64'(v.e_mis ? 1 : lat + 2));
        check({tag, " rsp_mis"}, 64'(got_mis), 64'(v.e_mis));
        check({tag, " rsp_err"}, 64'(got_err), 64'(v.e_err));
        check({tag, " rsp_data"}, 64'(got_data), 64'(v.e_data));
        check({tag, " req_count"}, 64'(nreq), 64'(v.e_mis ? 0 : 1));
        if (!v.e_mis) begin
            check({tag, " req_cycle"}, 64'(req_k), 64'd1);
            check({tag, " we"}, 64'(got_we), 64'(v.st));
            check({tag, " n_bytes"}, 64'(got_nb), 64'(v.f3[1:0]));
            check({tag, " addr"}, 64'(got_addr), 64'(v.addr));
            if (v.st) check({tag, " w_data"}, 64'(got_wd), 64'(v.e_wd));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[$];
    vec_t rv;
    int nrv;
    int nrq;

    initial begin
        tbl.push_back(mk(0, 3'd2, 16'h0010, 0, 32'hDEAD_BEEF, 0,
                         0, 0, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(0, 3'd0, 16'h0013, 0, 32'h80FF_0000, 0,
                         0, 0, 32'hFFFF_FF80, 0));
        tbl.push_back(mk(0, 3'd4, 16'h0013, 0, 32'h80FF_0000, 0,
                         0, 0, 32'h0000_0080, 0));
        tbl.push_back(mk(0, 3'd5, 16'h0012, 0, 32'h80FF_0000, 0,
                         0, 0, 32'h0000_80FF, 0));
        tbl.push_back(mk(1, 3'd0, 16'h0021, 32'h1234_56AB, 32'h5555_AAAA,
                         0, 0, 0, 32'h0, 32'hABAB_ABAB));
        tbl.push_back(mk(0, 3'd2, 16'h0006, 0, 32'h1111_1111, 0,
                         1, 0, 32'h0, 0));
        tbl.push_back(mk(1, 3'd1, 16'h0003, 32'h0000_BEEF, 0, 0,
                         1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 3'd2, 16'h0010, 0, 32'h1111_2222, 1,
                         0, 1, 32'h0, 0));
        tbl.push_back(mk(0, 3'd0, 16'hFFFF, 0, 32'h7F00_0000, 0,
                         0, 0, 32'h0000_007F, 0));
        tbl.push_back(mk(0, 3'd1, 16'h0002, 0, 32'h8001_0000, 0,
                         0, 0, 32'hFFFF_8001, 0));
        tbl.push_back(mk(1, 3'd1, 16'h0002, 32'hAAAA_5678, 0, 0,
                         0, 0, 32'h0, 32'h5678_5678));
        tbl.push_back(mk(1, 3'd2, 16'h0008, 32'hCAFE_F00D, 0, 0,
                         0, 0, 32'h0, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 3'd3, 16'h0000, 0, 32'hFFFF_FFFF, 0,
                         1, 0, 32'h0, 0));
        tbl.push_back(mk(1, 3'd4, 16'h0000, 32'h1, 0, 0,
                         1, 0, 32'h0, 0));
        tbl.push_back(mk(1, 3'd0, 16'h0044, 32'h0000_0077, 0, 1,
                         0, 1, 32'h0, 32'h7777_7777));
        tbl.push_back(mk(0, 3'd5, 16'h0010, 0, 32'h1234_F00F, 0,
                         0, 0, 32'h0000_F00F, 0));
        tbl.push_back(mk(0, 3'd4, 16'h0011, 0, 32'h1234_F00F, 0,
                         0, 0, 32'h0000_00F0, 0));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset op_ready", 64'(o_ready), 64'd1);
        check("reset rsp_valid", 64'(o_rv), 64'd0);
        check("reset rsp_data", 64'(o_data), 64'd0);
        check("reset rsp_err", 64'(o_err), 64'd0);
        check("reset rsp_misaligned", 64'(o_mis), 64'd0);
        check("reset mem_req", 64'(o_req), 64'd0);
        check("reset mem_write_en", 64'(o_we), 64'd0);
        check("reset mem_n_bytes", 64'(o_nb), 64'd0);
        check("reset mem_addr", 64'(o_addr), 64'd0);
        check("reset mem_w_data", 64'(o_wd), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i], 1, $sformatf("vec%0d", i));

        sel = 1'b1;
        run_op(tbl[7], 3, "lat3 err");
        run_op(tbl[0], 3, "lat3 lw");
        run_op(tbl[5], 3, "lat3 mis");
        sel = 1'b0;

        // op_valid held through RESP: second accept only from IDLE.
        op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'd2;
        op_addr = 16'h0006;
        @(posedge clk); #1;
        check("hold rsp1", 64'(o_rv), 64'd1);
        check("hold busy", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        check("hold gap rsp", 64'(o_rv), 64'd0);
        check("hold gap ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        check("hold rsp2", 64'(o_rv), 64'd1);
        op_valid = 1'b0;
        @(posedge clk); #1;
        check("hold idle", 64'(o_ready), 64'd1);

        // Reset while waiting on the slow memory.
        sel = 1'b1;
        op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'd2;
        op_addr = 16'h0040;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst ready", 64'(o_ready), 64'd1);
        check("rst rsp_valid", 64'(o_rv), 64'd0);
        nrv = 0; nrq = 0;
        for (int k = 0; k < 6; k++) begin
            mem_r_data = $urandom;
            @(posedge clk); #1;
            if (o_rv) nrv++;
            if (o_req) nrq++;
        end
        check("rst no rsp", 64'(nrv), 64'd0);
        check("rst no req", 64'(nrq), 64'd0);
        run_op(tbl[0], 3, "post_rst");

        for (int i = 0; i < 150; i++) begin
            int lat;
            rv.st = 1'($urandom_range(0, 1));
            rv.f3 = 3'($urandom_range(0, 7));
            rv.addr = AW'($urandom);
            if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.err = ($urandom_range(0, 7) == 0);
            rv = model(rv);
            lat = ($urandom_range(0, 1) == 1) ? 3 : 1;
            sel = (lat == 3);
            run_op(rv, lat, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
